// File: rtl/ifns_pkg.sv
// Shared types, widths and Fibonacci weight table for the 20-bit IFNS codec.
// Also holds the forbidden-triple detector used when IFNS_DECODER_CHECK_EN is defined.
package ifns_pkg;

  localparam int CW_W   = 29;
  localparam int DATA_W = 20;
  localparam int ACC_W  = 21;
  localparam int IDX_W  = $clog2(CW_W);

  typedef logic [CW_W-1:0]   cw_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // d1..d28 carry F(1)..F(28); d29 jumps to F(30) so the code spans 20 bits.
  localparam data_t IFNS_W [CW_W] = '{
    20'd1,      20'd1,      20'd2,      20'd3,      20'd5,
    20'd8,      20'd13,     20'd21,     20'd34,     20'd55,
    20'd89,     20'd144,    20'd233,    20'd377,    20'd610,
    20'd987,    20'd1597,   20'd2584,   20'd4181,   20'd6765,
    20'd10946,  20'd17711,  20'd28657,  20'd46368,  20'd75025,
    20'd121393, 20'd196418, 20'd317811, 20'd832040
  };

  function automatic logic has_forbidden(input cw_t cw);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k <= CW_W - 3; k++) begin
      if (cw[k +: 3] == 3'b010 || cw[k +: 3] == 3'b101) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/ifns_weight_sum.sv
// Combinational partial sum: adds the IFNS weights of a slice of codeword bits
// starting at codeword index base_i; positions past d29 contribute nothing.
module ifns_weight_sum
  import ifns_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 4,
  parameter int BASE_W         = 6
) (
  input  logic [BITS_PER_CYCLE-1:0] bits_i,
  input  logic [BASE_W-1:0]         base_i,
  output logic [ACC_W-1:0]          sum_o
);

  int pos;

  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    sum_o = '0;
    pos   = 0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      pos = int'(base_i) + i;
      if (bits_i[i] && pos < CW_W) begin
        sum_o = sum_o + ACC_W'(IFNS_W[IDX_W'(pos)]);
      end
    end
  end

endmodule

// File: rtl/ifns_20di_decoder_seq.sv
// Multi-cycle IFNS decoder: accumulates BITS_PER_CYCLE weighted codeword bits per clock.
// Optional legality checker enabled by defining IFNS_DECODER_CHECK_EN.
module ifns_20di_decoder_seq
  import ifns_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CW_W-1:0]   cw_i,
  input  logic              cw_valid_i,
  output logic              cw_ready_o,
  output logic [DATA_W-1:0] data_o,
  output logic              data_valid_o,
  input  logic              data_ready_i,
  output logic              err_o
);

  localparam int NUM_ITER = (CW_W + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
  localparam int ITER_W   = $clog2(NUM_ITER + 1);
  localparam int BASE_W   = 6;

  state_t             state_q;
  cw_t                cw_q;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   acc_d;
  logic [ACC_W-1:0]   step_sum;
  logic [ITER_W-1:0]  iter_q;
  logic [BASE_W-1:0]  base_idx;
  data_t              data_q;
  logic               valid_q;
  logic               err_q;
  logic               err_d;

  assign base_idx = BASE_W'(int'(iter_q) * BITS_PER_CYCLE);

  ifns_weight_sum #(
    .BITS_PER_CYCLE (BITS_PER_CYCLE),
    .BASE_W         (BASE_W)
  ) u_weight_sum (
    .bits_i (cw_q[BITS_PER_CYCLE-1:0]),
    .base_i (base_idx),
    .sum_o  (step_sum)
  );

  assign acc_d = acc_q + step_sum;

`ifdef IFNS_DECODER_CHECK_EN
  logic flag_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_q <= 1'b0;
    end else if (state_q == ST_IDLE && cw_valid_i) begin
      flag_q <= has_forbidden(cw_i);
    end
  end

  assign err_d = acc_q[ACC_W-1] | flag_q;
`else
  assign err_d = acc_q[ACC_W-1];
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cw_q    <= '0;
      acc_q   <= '0;
      iter_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cw_valid_i) begin
            cw_q    <= cw_i;
            acc_q   <= '0;
            iter_q  <= '0;
            state_q <= ST_ACC;
          end
        end
        ST_ACC: begin
          acc_q  <= acc_d;
          cw_q   <= cw_q >> BITS_PER_CYCLE;
          iter_q <= iter_q + ITER_W'(1);
          if (iter_q == ITER_W'(NUM_ITER - 1)) state_q <= ST_DONE;
        end
        ST_DONE: begin
          // First DONE cycle publishes the result; later cycles wait for the consumer.
          if (!valid_q) begin
            valid_q <= 1'b1;
            data_q  <= acc_q[DATA_W-1:0];
            err_q   <= err_d;
          end else if (data_ready_i) begin
            valid_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cw_ready_o   = (state_q == ST_IDLE) && !rst;
  assign data_o       = data_q;
  assign data_valid_o = valid_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_ifns_20di_decoder_seq.sv
// Randomized self-checking bench for ifns_20di_decoder_seq against a Fibonacci-sum model.
// Honours IFNS_DECODER_CHECK_EN when computing expected err_o.
module tb_ifns_20di_decoder_seq;

  localparam int BPC      = 4;
  localparam int NUM_ITER = (29 + BPC - 1) / BPC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [28:0] cw_i = '0;
  logic        cw_valid_i = 1'b0;
  logic        cw_ready_o;
  logic [19:0] data_o;
  logic        data_valid_o;
  logic        data_ready_i = 1'b0;
  logic        err_o;

  int n_tests = 0;
  int n_fail  = 0;

  ifns_20di_decoder_seq #(.BITS_PER_CYCLE(BPC)) dut (
    .clk          (clk),
    .rst          (rst),
    .cw_i         (cw_i),
    .cw_valid_i   (cw_valid_i),
    .cw_ready_o   (cw_ready_o),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .data_ready_i (data_ready_i),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: walk the Fibonacci sequence; d1..d28 take F(1)..F(28), d29 takes F(30).
  function automatic int unsigned ref_sum(input logic [28:0] cw);
    int unsigned fprev = 0, fcur = 1, t, sum = 0;
    for (int k = 1; k <= 30; k++) begin
      if (k <= 28 && cw[k-1]) sum += fcur;
      if (k == 30 && cw[28])  sum += fcur;
      t = fprev + fcur;
      fprev = fcur;
      fcur = t;
    end
    return sum;
  endfunction

  function automatic logic ref_err(input logic [28:0] cw);
    logic e;
    e = ref_sum(cw) >= 32'd1048576;
`ifdef IFNS_DECODER_CHECK_EN
    for (int k = 0; k < 27; k++)
      if (cw[k] != cw[k+1] && cw[k+2] != cw[k+1]) e = 1'b1;
`endif
    return e;
  endfunction

  task automatic run_word(input string name, input logic [28:0] cw, input int stall);
    int unsigned exp_sum;
    int w, cyc, bad;
    logic [19:0] held_data;
    logic held_err;
    exp_sum = ref_sum(cw);
    w = 0;
    while (!cw_ready_o && w < 20) begin
      @(posedge clk); #1; w++;
    end
    check({name, "_ready"}, 32'(cw_ready_o), 32'd1);
    cw_valid_i = 1'b1;
    cw_i = cw;
    @(posedge clk); #1;
    cw_valid_i = 1'b0;
    cw_i = 29'($urandom);
    cyc = 0;
    bad = 0;
    while (!data_valid_o && cyc < 30) begin
      data_ready_i = (cyc < NUM_ITER) ? 1'($urandom_range(0, 1)) : 1'b0;
      cw_valid_i = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      cyc++;
      if (cw_ready_o) bad++;
    end
    cw_valid_i = 1'b0;
    check({name, "_latency"}, 32'(cyc), 32'(NUM_ITER + 1));
    check({name, "_busy_ready"}, 32'(bad), 32'd0);
    check({name, "_data"}, 32'(data_o), exp_sum & 32'hF_FFFF);
    check({name, "_err"}, 32'(err_o), 32'(ref_err(cw)));
    held_data = data_o;
    held_err = err_o;
    bad = 0;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      if (data_o !== held_data || err_o !== held_err || !data_valid_o || cw_ready_o) bad++;
    end
    check({name, "_stall_hold"}, 32'(bad), 32'd0);
    data_ready_i = 1'b1;
    @(posedge clk); #1;
    data_ready_i = 1'b0;
    check({name, "_release_valid"}, 32'(data_valid_o), 32'd0);
    check({name, "_release_ready"}, 32'(cw_ready_o), 32'd1);
  endtask

  task automatic reset_mid_acc();
    int bad;
    cw_valid_i = 1'b1;
    cw_i = 29'h1FFF_FFFF;
    @(posedge clk); #1;
    cw_valid_i = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    check("rst_mid_valid", 32'(data_valid_o), 32'd0);
    check("rst_mid_ready", 32'(cw_ready_o), 32'd0);
    check("rst_mid_data", 32'(data_o), 32'd0);
    check("rst_mid_err", 32'(err_o), 32'd0);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check("rst_mid_ready_after", 32'(cw_ready_o), 32'd1);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (data_valid_o) bad++;
    end
    check("rst_mid_no_stale", 32'(bad), 32'd0);
  endtask

  initial begin
    logic [28:0] rcw;
    #1;
    check("rst_ready", 32'(cw_ready_o), 32'd0);
    check("rst_valid", 32'(data_valid_o), 32'd0);
    check("rst_data", 32'(data_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    #22 rst = 1'b0;
    #1;
    check("rst_release_ready", 32'(cw_ready_o), 32'd1);
    @(posedge clk); #1;

    run_word("zero", 29'h0000_0000, 0);
    run_word("d29", 29'h1000_0000, 0);
    run_word("d28_d1", 29'h0FFF_FFFF, 0);
    run_word("all_ones", 29'h1FFF_FFFF, 0);
    run_word("pattern101", 29'h0000_0005, 0);
    run_word("backpressure", 29'h0AAA_5555, 5);
    run_word("pre_reset", 29'h1FFF_FFFF, 0);
    reset_mid_acc();
    run_word("after_reset", 29'h0000_0003, 0);

    for (int i = 0; i < 40; i++) begin
      rcw = 29'($urandom);
      if (i % 3 == 0) rcw = rcw & 29'h0FFF_FFFF;
      if (i % 5 == 1) rcw = rcw & ~(rcw >> 1);
      run_word($sformatf("rand%0d", i), rcw, int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
